mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_tmo_cnt.sv | 29 ++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU width, FSM state and owner encodings for the
// memory arbiter slice.
package mem_arbiter_pkg;

    localparam int unsigned CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_tmo_cnt.sv
// arb_tmo_cnt: 8-bit response wait counter. Cleared when the request is
// accepted by memory, counts every WAIT cycle; hit flags the WAIT cycle in
// which the count reaches TMO_CYC.
module arb_tmo_cnt #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] r_cnt;

    // Wait-cycle counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign hit = en && (r_cnt == 8'(TMO_CYC - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and
// load/store, one transaction outstanding at a time, with a wait timeout.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration instead of
// fixed LSU priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = CPU_WIDTH,
    parameter int unsigned DATA_W  = CPU_WIDTH,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    arb_owner_e        r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_wmask;
    logic              r_ifu_resp;
    logic              r_lsu_resp;
    logic              r_lsu_err;
    logic [DATA_W-1:0] r_rdata;

    logic w_pick_lsu;
    logic w_ifu_ready;
    logic w_lsu_ready;
    logic w_hs;
    logic w_done;
    logic w_tmo;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_tmo_hit;

`ifdef MEM_ARB_RR_EN
    arb_owner_e r_last;

    // Remember the last winner so a tie goes to the other requester
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= OWN_IFU;
        end else if (w_hs) begin
            r_last <= w_lsu_ready ? OWN_LSU : OWN_IFU;
        end
    end

    assign w_pick_lsu = lsu_req_valid && (!ifu_req_valid || (r_last == OWN_IFU));
`else
    assign w_pick_lsu = lsu_req_valid;
`endif

    assign w_hs      = w_ifu_ready || w_lsu_ready;
    assign w_cnt_clr = (r_state == ISSUE) && mem_req_ready;
    assign w_cnt_en  = (r_state == WAIT);

    arb_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .hit   (w_tmo_hit)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, next-state and completion decode; a response that coincides
    // with the timeout hit wins over the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_ifu_ready = 1'b0;
        w_lsu_ready = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_lsu_ready = w_pick_lsu && !i_rst;
                w_ifu_ready = ifu_req_valid && !w_pick_lsu && !i_rst;
                if (w_lsu_ready || w_ifu_ready) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                    w_tmo       = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latches and registered response strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_owner    <= OWN_IFU;
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_ifu_resp <= 1'b0;
            r_lsu_resp <= 1'b0;
            r_lsu_err  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ifu_resp <= w_done && (r_owner == OWN_IFU);
            r_lsu_resp <= w_done && (r_owner == OWN_LSU);
            r_lsu_err  <= w_done && w_tmo && (r_owner == OWN_LSU);
            if (w_done) begin
                r_rdata <= w_tmo ? '0 : mem_rdata;
            end
            if (w_hs) begin
                r_owner <= w_lsu_ready ? OWN_LSU : OWN_IFU;
                r_addr  <= w_lsu_ready ? lsu_addr : ifu_addr;
                r_wen   <= w_lsu_ready && lsu_wen;
                r_wdata <= w_lsu_ready ? lsu_wdata : '0;
                r_wmask <= w_lsu_ready ? lsu_wmask : '0;
            end
        end
    end

    assign ifu_req_ready  = w_ifu_ready;
    assign lsu_req_ready  = w_lsu_ready;
    assign ifu_resp_valid = r_ifu_resp;
    assign lsu_resp_valid = r_lsu_resp;
    assign lsu_err        = r_lsu_err;
    assign ifu_rdata      = r_rdata;
    assign lsu_rdata      = r_rdata;
    assign mem_req_valid  = (r_state == ISSUE);
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;

endmodule
